// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush-to-bubble and a two-state valid tracker.
// Optional bubble counter output is enabled by defining IDEX_BUBBLE_CNT_EN.
module id_ex_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    output logic            ValidE,
    input  logic [1:0]      ResultSrcD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic [1:0]      BranchTypeD,
    input  logic            JalrD,
    input  logic            LuiD,
    input  logic            ALUSrcD,
    input  logic            RegWriteD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [1:0]      BranchTypeE,
    output logic            JalrE,
    output logic            LuiE,
    output logic            ALUSrcE,
    output logic            RegWriteE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
`ifdef IDEX_BUBBLE_CNT_EN
    ,
    output logic [15:0]     BubbleCnt
`endif
);

    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic [1:0]      ResultSrc;
        logic            MemWrite;
        logic            Jump;
        logic            Branch;
        logic [1:0]      BranchType;
        logic            Jalr;
        logic            Lui;
        logic            ALUSrc;
        logic            RegWrite;
        logic [2:0]      ALUControl;
        logic [XLEN-1:0] RD1;
        logic [XLEN-1:0] RD2;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] ImmExt;
        logic [XLEN-1:0] PCPlus4;
        logic [4:0]      Rs1;
        logic [4:0]      Rs2;
        logic [4:0]      Rd;
    } payload_t;

    state_t   state_q, state_d;
    payload_t pay_q, pay_d, pay_in;

    assign pay_in = '{ResultSrc: ResultSrcD, MemWrite: MemWriteD, Jump: JumpD,
                      Branch: BranchD, BranchType: BranchTypeD, Jalr: JalrD,
                      Lui: LuiD, ALUSrc: ALUSrcD, RegWrite: RegWriteD,
                      ALUControl: ALUControlD, RD1: RD1D, RD2: RD2D, PC: PCD,
                      ImmExt: ImmExtD, PCPlus4: PCPlus4D, Rs1: Rs1D, Rs2: Rs2D,
                      Rd: RdD};

    // A bubble is an all-zero payload, so EMPTY can never carry a write enable.
    always_comb begin
        state_d = state_q;
        pay_d   = pay_q;
        if (FlushE) begin
            state_d = EMPTY;
            pay_d   = '0;
        end else if (!StallE) begin
            if (ValidD) begin
                state_d = FULL;
                pay_d   = pay_in;
            end else begin
                state_d = EMPTY;
                pay_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            pay_q   <= '0;
        end else begin
            state_q <= state_d;
            pay_q   <= pay_d;
        end
    end

    assign ValidE      = (state_q == FULL);
    assign ResultSrcE  = pay_q.ResultSrc;
    assign MemWriteE   = pay_q.MemWrite;
    assign JumpE       = pay_q.Jump;
    assign BranchE     = pay_q.Branch;
    assign BranchTypeE = pay_q.BranchType;
    assign JalrE       = pay_q.Jalr;
    assign LuiE        = pay_q.Lui;
    assign ALUSrcE     = pay_q.ALUSrc;
    assign RegWriteE   = pay_q.RegWrite;
    assign ALUControlE = pay_q.ALUControl;
    assign RD1E        = pay_q.RD1;
    assign RD2E        = pay_q.RD2;
    assign PCE         = pay_q.PC;
    assign ImmExtE     = pay_q.ImmExt;
    assign PCPlus4E    = pay_q.PCPlus4;
    assign Rs1E        = pay_q.Rs1;
    assign Rs2E        = pay_q.Rs2;
    assign RdE         = pay_q.Rd;

`ifdef IDEX_BUBBLE_CNT_EN
    logic        bubble_load;
    logic [15:0] cnt_q, cnt_d;

    // Counts flushes and invalid loads; saturates rather than wrapping.
    assign bubble_load = FlushE || (!StallE && !ValidD);

    always_comb begin
        cnt_d = cnt_q;
        if (bubble_load && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign BubbleCnt = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed steps plus randomized traffic against a reference model.
// Counter checks are compiled in when IDEX_BUBBLE_CNT_EN is defined.
module tb_id_ex_reg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [1:0]      ResultSrc;
        logic            MemWrite;
        logic            Jump;
        logic            Branch;
        logic [1:0]      BranchType;
        logic            Jalr;
        logic            Lui;
        logic            ALUSrc;
        logic            RegWrite;
        logic [2:0]      ALUControl;
        logic [XLEN-1:0] RD1;
        logic [XLEN-1:0] RD2;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] ImmExt;
        logic [XLEN-1:0] PCPlus4;
        logic [4:0]      Rs1;
        logic [4:0]      Rs2;
        logic [4:0]      Rd;
    } stage_t;

    logic   clk = 1'b0;
    logic   rst_n, StallE, FlushE, ValidD;
    stage_t dIn;

    logic            ValidE;
    logic [1:0]      ResultSrcE, BranchTypeE;
    logic            MemWriteE, JumpE, BranchE, JalrE, LuiE, ALUSrcE, RegWriteE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]      Rs1E, Rs2E, RdE;
`ifdef IDEX_BUBBLE_CNT_EN
    logic [15:0]     BubbleCnt;
`endif

    stage_t      expStage;
    logic        expValid;
    int unsigned expCnt;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
        .ValidD(ValidD), .ValidE(ValidE),
        .ResultSrcD(dIn.ResultSrc), .MemWriteD(dIn.MemWrite), .JumpD(dIn.Jump),
        .BranchD(dIn.Branch), .BranchTypeD(dIn.BranchType), .JalrD(dIn.Jalr),
        .LuiD(dIn.Lui), .ALUSrcD(dIn.ALUSrc), .RegWriteD(dIn.RegWrite),
        .ALUControlD(dIn.ALUControl), .RD1D(dIn.RD1), .RD2D(dIn.RD2),
        .PCD(dIn.PC), .ImmExtD(dIn.ImmExt), .PCPlus4D(dIn.PCPlus4),
        .Rs1D(dIn.Rs1), .Rs2D(dIn.Rs2), .RdD(dIn.Rd),
        .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .BranchTypeE(BranchTypeE), .JalrE(JalrE),
        .LuiE(LuiE), .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
        .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE)
`ifdef IDEX_BUBBLE_CNT_EN
        , .BubbleCnt(BubbleCnt)
`endif
    );

    task automatic checkField(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour: reset clears, flush wins, stall holds, otherwise load or bubble.
    task automatic modelEdge();
        if (!rst_n) begin
            expStage = '0;
            expValid = 1'b0;
            expCnt   = 0;
        end else if (FlushE || (!StallE && !ValidD)) begin
            expStage = '0;
            expValid = 1'b0;
            if (expCnt < 65535) expCnt++;
        end else if (!StallE) begin
            expStage = dIn;
            expValid = 1'b1;
        end
    endtask

    task automatic checkOutput();
        checkField("ValidE", ValidE, expValid);
        checkField("ResultSrcE", ResultSrcE, expStage.ResultSrc);
        checkField("MemWriteE", MemWriteE, expStage.MemWrite);
        checkField("JumpE", JumpE, expStage.Jump);
        checkField("BranchE", BranchE, expStage.Branch);
        checkField("BranchTypeE", BranchTypeE, expStage.BranchType);
        checkField("JalrE", JalrE, expStage.Jalr);
        checkField("LuiE", LuiE, expStage.Lui);
        checkField("ALUSrcE", ALUSrcE, expStage.ALUSrc);
        checkField("RegWriteE", RegWriteE, expStage.RegWrite);
        checkField("ALUControlE", ALUControlE, expStage.ALUControl);
        checkField("RD1E", RD1E, expStage.RD1);
        checkField("RD2E", RD2E, expStage.RD2);
        checkField("PCE", PCE, expStage.PC);
        checkField("ImmExtE", ImmExtE, expStage.ImmExt);
        checkField("PCPlus4E", PCPlus4E, expStage.PCPlus4);
        checkField("Rs1E", Rs1E, expStage.Rs1);
        checkField("Rs2E", Rs2E, expStage.Rs2);
        checkField("RdE", RdE, expStage.Rd);
        checkField("bubbleSideEffect", !ValidE && (RegWriteE || MemWriteE), 1'b0);
`ifdef IDEX_BUBBLE_CNT_EN
        checkField("BubbleCnt", BubbleCnt, expCnt[15:0]);
`endif
    endtask

    task automatic applyStimulus(input logic rstN, input logic stall, input logic flush);
        rst_n  = rstN;
        StallE = stall;
        FlushE = flush;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    function automatic stage_t randomStage();
        stage_t s;
        s.ResultSrc  = 2'($urandom);
        s.MemWrite   = 1'($urandom);
        s.Jump       = 1'($urandom);
        s.Branch     = 1'($urandom);
        s.BranchType = 2'($urandom);
        s.Jalr       = 1'($urandom);
        s.Lui        = 1'($urandom);
        s.ALUSrc     = 1'($urandom);
        s.RegWrite   = 1'($urandom);
        s.ALUControl = 3'($urandom);
        s.RD1        = $urandom;
        s.RD2        = $urandom;
        s.PC         = $urandom;
        s.ImmExt     = $urandom;
        s.PCPlus4    = $urandom;
        s.Rs1        = 5'($urandom);
        s.Rs2        = 5'($urandom);
        s.Rd         = 5'($urandom);
        return s;
    endfunction

    initial begin
        expStage = '0;
        expValid = 1'b0;
        expCnt   = 0;
        rst_n    = 1'b0;
        StallE   = 1'b0;
        FlushE   = 1'b0;

        // Reset with every decode input driven high.
        ValidD = 1'b1;
        dIn    = '1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkField("resetValid", ValidE, 1'b0);
        checkField("resetRD1", RD1E, 32'h0);

        // Single-edge pass-through.
        dIn            = '0;
        dIn.RegWrite   = 1'b1;
        dIn.ALUControl = 3'b010;
        dIn.RD1        = 32'h1234_5678;
        dIn.Rd         = 5'd7;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkField("passRD1", RD1E, 32'h1234_5678);
        checkField("passRd", RdE, 5'd7);

        // Stall holds the first PC while decode moves on.
        dIn.PC = 32'h0000_0040;
        applyStimulus(1'b1, 1'b0, 1'b0);
        dIn.PC = 32'h0000_0044;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkField("stallHoldPC", PCE, 32'h0000_0040);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkField("stallReleasePC", PCE, 32'h0000_0044);

        // Flush beats a simultaneous stall.
        dIn.MemWrite = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkField("preFlushMemWrite", MemWriteE, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkField("flushMemWrite", MemWriteE, 1'b0);
        checkField("flushRd", RdE, 5'd0);

        // Invalid decode slot becomes a bubble.
        ValidD       = 1'b0;
        dIn.RegWrite = 1'b1;
        dIn.MemWrite = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkField("invalidRegWrite", RegWriteE, 1'b0);

        // x0 destination passes through untouched.
        ValidD       = 1'b1;
        dIn.Rd       = 5'd0;
        dIn.MemWrite = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkField("x0RegWrite", RegWriteE, 1'b1);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 400; i++) begin
            dIn    = randomStage();
            ValidD = ($urandom_range(0, 3) != 0);
            applyStimulus($urandom_range(0, 31) != 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 5) == 0);
        end

        // Reset in the middle of a stall drops the held instruction.
        dIn    = randomStage();
        ValidD = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkField("midResetValid", ValidE, 1'b0);

`ifdef IDEX_BUBBLE_CNT_EN
        // Counter saturation, then reset back to zero.
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65537; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
        end
        checkField("satCnt", BubbleCnt, 16'hFFFF);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkField("satHold", BubbleCnt, 16'hFFFF);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkField("satReset", BubbleCnt, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
